// File: rtl/rv32_pkg.sv
// Shared constants for the RV32 multi-cycle controller: opcodes, FSM states,
// ALU operation codes and datapath select encodings.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXER, EXEI, ALUWB, BRANCH, JAL, ILLEGAL
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Immediate format is a pure function of the opcode, independent of state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return 2'b01;
      OP_BRANCH: return 2'b10;
      OP_JAL:    return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu_dec.sv
// Funct-field decode for ALU instructions and branch-condition evaluation
// from the {N,Z,C,V} flags.
module rv32_alu_dec
  import rv32_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] alu_flg,
  output alu_ctrl_e  alu_ctrl,
  output logic       alu_illegal,
  output logic       br_taken,
  output logic       br_illegal
);

  logic flg_n, flg_z, flg_c, flg_v;
  assign {flg_n, flg_z, flg_c, flg_v} = alu_flg;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    alu_ctrl    = ALU_ADD;
    alu_illegal = 1'b0;
    case (funct3)
      3'b000:  alu_ctrl = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_ctrl = ALU_SLT;
      3'b110:  alu_ctrl = ALU_OR;
      3'b111:  alu_ctrl = ALU_AND;
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    br_taken   = 1'b0;
    br_illegal = 1'b0;
    case (funct3)
      3'b000:  br_taken = flg_z;
      3'b001:  br_taken = !flg_z;
      3'b100:  br_taken = flg_n ^ flg_v;
      3'b101:  br_taken = !(flg_n ^ flg_v);
      3'b110:  br_taken = !flg_c;
      3'b111:  br_taken = flg_c;
      default: br_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_mc_ctrl.sv
// Moore-style main controller for a multi-cycle RV32 datapath: sequences
// fetch/decode/execute and raises an absorbing ILLEGAL state on bad encodings.
module rv32_mc_ctrl
  import rv32_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic [3:0] alu_flg_i,
  input  logic       mem_rdy_i,
  output logic       pc_we_o,
  output logic       ir_we_o,
  output logic       mem_we_o,
  output logic       reg_we_o,
  output logic       adr_src_o,
  output logic [1:0] alu_srcA_o,
  output logic [1:0] alu_srcB_o,
  output logic [1:0] result_src_o,
  output logic [1:0] imm_src_o,
  output logic [2:0] alu_ctrl_o,
  output logic       illegal_o
);

  state_e    state_q, state_d;
  alu_ctrl_e dec_alu_ctrl, alu_ctrl;
  logic      dec_alu_illegal, br_taken, br_illegal;
  logic      rdy;
  logic      pc_we, ir_we, mem_we, reg_we, illegal;

  assign rdy = (MEM_WAIT_EN != 0) ? mem_rdy_i : 1'b1;

  rv32_alu_dec u_alu_dec (
    .op          (op_i),
    .funct3      (funct3_i),
    .funct7b5    (funct7b5_i),
    .alu_flg     (alu_flg_i),
    .alu_ctrl    (dec_alu_ctrl),
    .alu_illegal (dec_alu_illegal),
    .br_taken    (br_taken),
    .br_illegal  (br_illegal)
  );

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    mem_we       = 1'b0;
    reg_we       = 1'b0;
    illegal      = 1'b0;
    adr_src_o    = 1'b0;
    alu_srcA_o   = SRCA_PC;
    alu_srcB_o   = SRCB_RS2;
    result_src_o = RES_ALUOUT;
    alu_ctrl     = ALU_ADD;
    case (state_q)
      FETCH: begin
        alu_srcB_o   = SRCB_FOUR;
        result_src_o = RES_ALU;
        pc_we        = rdy;
        ir_we        = rdy;
        if (rdy) state_d = DECODE;
      end
      DECODE: begin
        alu_srcA_o = SRCA_OLDPC;
        alu_srcB_o = SRCB_IMM;
        case (op_i)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXER;
          OP_I:              state_d = EXEI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default:           state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alu_srcA_o = SRCA_RS1;
        alu_srcB_o = SRCB_IMM;
        state_d    = (op_i == OP_STORE) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        adr_src_o = 1'b1;
        if (rdy) state_d = MEMWB;
      end
      MEMWB: begin
        result_src_o = RES_RDATA;
        reg_we       = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        adr_src_o = 1'b1;
        mem_we    = 1'b1;
        if (rdy) state_d = FETCH;
      end
      EXER, EXEI: begin
        alu_srcA_o = SRCA_RS1;
        alu_srcB_o = (state_q == EXEI) ? SRCB_IMM : SRCB_RS2;
        alu_ctrl   = dec_alu_ctrl;
        state_d    = dec_alu_illegal ? ILLEGAL : ALUWB;
      end
      ALUWB: begin
        reg_we  = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        alu_srcA_o = SRCA_RS1;
        alu_ctrl   = ALU_SUB;
        pc_we      = br_taken;
        state_d    = br_illegal ? ILLEGAL : FETCH;
      end
      JAL: begin
        alu_srcA_o = SRCA_OLDPC;
        alu_srcB_o = SRCB_FOUR;
        pc_we      = 1'b1;
        state_d    = ALUWB;
      end
      ILLEGAL: illegal = 1'b1;
      default: state_d = ILLEGAL;
    endcase
  end

  // Reset gates the write enables directly so an in-flight store is cut off
  // the instant rst_ni falls, not at the next clock edge.
  assign pc_we_o    = pc_we   & rst_ni;
  assign ir_we_o    = ir_we   & rst_ni;
  assign mem_we_o   = mem_we  & rst_ni;
  assign reg_we_o   = reg_we  & rst_ni;
  assign illegal_o  = illegal & rst_ni;
  assign alu_ctrl_o = alu_ctrl;
  assign imm_src_o  = imm_src_of(op_i);

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Scoreboard bench for rv32_mc_ctrl: an instruction-level model expands each
// instruction into expected per-cycle control vectors; a monitor compares them.
module tb_rv32_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op_i = 7'b0110011;
  logic [2:0] funct3_i = 3'b000;
  logic       funct7b5_i = 1'b0;
  logic [3:0] alu_flg_i = 4'b0000;
  logic       mem_rdy = 1'b1;
  logic       pc_we, ir_we, mem_we, reg_we, adr_src, illegal;
  logic [1:0] src_a, src_b, res_src, imm_src;
  logic [2:0] alu_ctrl;

  always #5 clk = ~clk;

  rv32_mc_ctrl #(.MEM_WAIT_EN(1)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .op_i         (op_i),
    .funct3_i     (funct3_i),
    .funct7b5_i   (funct7b5_i),
    .alu_flg_i    (alu_flg_i),
    .mem_rdy_i    (mem_rdy),
    .pc_we_o      (pc_we),
    .ir_we_o      (ir_we),
    .mem_we_o     (mem_we),
    .reg_we_o     (reg_we),
    .adr_src_o    (adr_src),
    .alu_srcA_o   (src_a),
    .alu_srcB_o   (src_b),
    .result_src_o (res_src),
    .imm_src_o    (imm_src),
    .alu_ctrl_o   (alu_ctrl),
    .illegal_o    (illegal)
  );

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       mem_we;
    logic       reg_we;
    logic       adr_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res_src;
    logic [1:0] imm_src;
    logic [2:0] alu;
    logic       illegal;
  } exp_t;

  typedef struct packed {
    exp_t e;
    logic rdy;
  } step_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  exp_t  sb[$];
  step_t plan[$];
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t sample();
    exp_t g;
    g = '{pc_we, ir_we, mem_we, reg_we, adr_src, src_a, src_b, res_src, imm_src, alu_ctrl, illegal};
    return g;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t base(input logic [6:0] op);
    exp_t e = '0;
    if (op == SW) e.imm_src = 2'd1;
    else if (op == BR) e.imm_src = 2'd2;
    else if (op == JL) e.imm_src = 2'd3;
    return e;
  endfunction

  function automatic exp_t fetch_exp(input logic [6:0] op, input logic rdy);
    exp_t e = base(op);
    e.src_b   = 2'b10;
    e.res_src = 2'b10;
    e.pc_we   = rdy;
    e.ir_we   = rdy;
    return e;
  endfunction

  task automatic add_step(input exp_t e, input logic rdy);
    step_t s;
    s.e   = e;
    s.rdy = rdy;
    plan.push_back(s);
  endtask

  // Expands one instruction into its expected cycle-by-cycle control vectors.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [3:0] flg, input int fw, input int mw, output logic ill);
    exp_t e;
    logic legal, taken;
    logic [2:0] alu;
    logic n, z, c, v;
    {n, z, c, v} = flg;
    ill = 1'b0;
    for (int i = 0; i < fw; i++) add_step(fetch_exp(op, 1'b0), 1'b0);
    add_step(fetch_exp(op, 1'b1), 1'b1);
    e = base(op); e.src_a = 2'b01; e.src_b = 2'b01;
    add_step(e, rb());
    case (op)
      LW, SW: begin
        e = base(op); e.src_a = 2'b10; e.src_b = 2'b01;
        add_step(e, rb());
        for (int i = 0; i <= mw; i++) begin
          e = base(op); e.adr_src = 1'b1; e.mem_we = (op == SW);
          add_step(e, i == mw);
        end
        if (op == LW) begin
          e = base(op); e.res_src = 2'b01; e.reg_we = 1'b1;
          add_step(e, rb());
        end
      end
      RT, IT: begin
        legal = 1'b1;
        alu   = 3'b000;
        case (f3)
          3'd0:    alu = (op == RT && f7) ? 3'b001 : 3'b000;
          3'd2:    alu = 3'b101;
          3'd6:    alu = 3'b011;
          3'd7:    alu = 3'b010;
          default: legal = 1'b0;
        endcase
        e = base(op); e.src_a = 2'b10; e.src_b = (op == IT) ? 2'b01 : 2'b00; e.alu = alu;
        add_step(e, rb());
        if (legal) begin
          e = base(op); e.reg_we = 1'b1;
          add_step(e, rb());
        end else ill = 1'b1;
      end
      BR: begin
        legal = 1'b1;
        taken = 1'b0;
        case (f3)
          3'd0:    taken = z;
          3'd1:    taken = !z;
          3'd4:    taken = (n != v);
          3'd5:    taken = (n == v);
          3'd6:    taken = !c;
          3'd7:    taken = c;
          default: legal = 1'b0;
        endcase
        e = base(op); e.src_a = 2'b10; e.alu = 3'b001; e.pc_we = taken;
        add_step(e, rb());
        ill = !legal;
      end
      JL: begin
        e = base(op); e.src_a = 2'b01; e.src_b = 2'b10; e.pc_we = 1'b1;
        add_step(e, rb());
        e = base(op); e.reg_we = 1'b1;
        add_step(e, rb());
      end
      default: ill = 1'b1;
    endcase
  endtask

  // Drives the planned cycles; starts and ends 1 time unit after a rising edge.
  task automatic run_plan(input int limit);
    step_t s;
    int n = 0;
    while (plan.size() > 0 && n < limit) begin
      s = plan.pop_front();
      mem_rdy = s.rdy;
      sb.push_back(s.e);
      @(posedge clk);
      #1;
      n++;
    end
    plan.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    exp_t e = base(op_i);
    e.src_b   = 2'b10;
    e.res_src = 2'b10;
    check(name, 32'(sample()), 32'(e));
  endtask

  task automatic do_reset();
    mem_rdy = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    @(posedge clk);
    #1 check_reset_outputs("reset_hold");
    mem_rdy = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [3:0] flg, input int fw, input int mw);
    logic ill;
    exp_t e;
    build(op, f3, f7, flg, fw, mw, ill);
    op_i = op; funct3_i = f3; funct7b5_i = f7; alu_flg_i = flg;
    run_plan(1 << 30);
    if (ill) begin
      e = base(op); e.illegal = 1'b1;
      for (int i = 0; i < 12; i++) add_step(e, rb());
      run_plan(1 << 30);
      do_reset();
    end
  endtask

  initial begin
    exp_t g;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        g = sb.pop_front();
        check("cycle_vector", 32'(sample()), 32'(g));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic ill;
    logic [6:0] op;
    #3 check_reset_outputs("reset_initial");
    @(posedge clk);
    mem_rdy = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(RT, 3'b000, 1'b0, 4'b0000, 0, 0);
    issue(RT, 3'b000, 1'b1, 4'b0000, 0, 0);
    issue(IT, 3'b000, 1'b1, 4'b0000, 1, 0);
    issue(IT, 3'b110, 1'b0, 4'b0000, 0, 0);
    issue(RT, 3'b001, 1'b0, 4'b0000, 0, 0);
    issue(LW, 3'b010, 1'b0, 4'b0000, 0, 3);
    issue(BR, 3'b000, 1'b0, 4'b0100, 0, 0);
    issue(BR, 3'b000, 1'b0, 4'b0000, 0, 0);
    issue(BR, 3'b110, 1'b0, 4'b0000, 0, 0);
    issue(7'b1111111, 3'b000, 1'b0, 4'b0000, 0, 0);

    // Store interrupted by reset during its memory wait.
    build(SW, 3'b010, 1'b0, 4'b0000, 1, 5, ill);
    op_i = SW; funct3_i = 3'b010; funct7b5_i = 1'b0;
    run_plan(5);
    mem_rdy = 1'b0;
    check("memwr_we_before_reset", 32'(mem_we), 32'd1);
    do_reset();
    issue(RT, 3'b111, 1'b0, 4'b0000, 0, 0);

    for (int k = 0; k < 250; k++) begin
      case ($urandom_range(0, 9))
        0:       op = LW;
        1:       op = SW;
        2, 3:    op = RT;
        4, 5:    op = IT;
        6, 7:    op = BR;
        8:       op = JL;
        default: op = 7'($urandom_range(0, 127));
      endcase
      issue(op, 3'($urandom_range(0, 7)), rb(), 4'($urandom_range(0, 15)),
            int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_mc_ctrl.md
RV32_MC_CTRL -- requirements
Module: rv32_mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1, meaning 1 = honour mem_rdy_i and 0 = treat memory as always ready.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port op_i, input, 7 bits: instruction opcode field.
REQ-005 SHALL have port funct3_i, input, 3 bits: instruction funct3 field.
REQ-006 SHALL have port funct7b5_i, input, 1 bit: instruction bit 30.
REQ-007 SHALL have port alu_flg_i, input, 4 bits: ALU flags {N,Z,C,V}.
REQ-008 SHALL have port mem_rdy_i, input, 1 bit: the memory access completes this cycle.
REQ-009 SHALL have port pc_we_o, output, 1 bit: PC write enable.
REQ-010 SHALL have port ir_we_o, output, 1 bit: instruction/oldPC register write enable.
REQ-011 SHALL have port mem_we_o, output, 1 bit: data memory write enable.
REQ-012 SHALL have port reg_we_o, output, 1 bit: register file write enable.
REQ-013 SHALL have port adr_src_o, output, 1 bit: memory address select (0 = PC, 1 = result).
REQ-014 SHALL have port alu_srcA_o, output, 2 bits: ALU A select (00 = PC, 01 = oldPC, 10 = rs1).
REQ-015 SHALL have port alu_srcB_o, output, 2 bits: ALU B select (00 = rs2, 01 = imm, 10 = const 4).
REQ-016 SHALL have port result_src_o, output, 2 bits: result select (00 = ALUOut, 01 = read data, 10 = ALU result direct).
REQ-017 SHALL have port imm_src_o, output, 2 bits: immediate format (00 = I, 01 = S, 10 = B, 11 = J).
REQ-018 SHALL have port alu_ctrl_o, output, 3 bits: ALU op code (000 add, 001 sub, 010 and, 011 or, 101 slt).
REQ-019 SHALL have port illegal_o, output, 1 bit: controller is in ILLEGAL.

Function
REQ-020 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXER, EXEI, ALUWB, BRANCH, JAL and ILLEGAL.
REQ-021 SHALL, in FETCH, drive adr_src 0, srcA 00, srcB 10, alu add and result_src 10; ir_we and pc_we SHALL be 1 only when mem_rdy_i is 1, and the FSM SHALL hold in FETCH otherwise.
REQ-022 SHALL, in DECODE, drive srcA 01, srcB 01 and add, then branch on op_i: 0000011/0100011 -> MEMADR, 0110011 -> EXER, 0010011 -> EXEI, 1100011 -> BRANCH, 1101111 -> JAL, any other opcode -> ILLEGAL.
REQ-023 SHALL, in MEMADR, drive srcA 10, srcB 01 and add, then go to MEMRD for a load or MEMWR for a store.
REQ-024 SHALL, in MEMRD, drive adr_src 1 and result_src 00, and hold in MEMRD until mem_rdy_i is 1, then go to MEMWB.
REQ-025 SHALL, in MEMWB, drive result_src 01 and reg_we 1, then go to FETCH.
REQ-026 SHALL, in MEMWR, drive adr_src 1, result_src 00 and mem_we 1; mem_we SHALL stay 1 while the FSM holds, and the FSM SHALL leave to FETCH on mem_rdy_i = 1.
REQ-027 SHALL, in EXER, drive srcA 10, srcB 00 and the funct-decoded op, then go to ALUWB.
REQ-028 SHALL, in EXEI, drive srcA 10, srcB 01 and the funct-decoded op, then go to ALUWB.
REQ-029 SHALL, in ALUWB, drive result_src 00 and reg_we 1, then go to FETCH.
REQ-030 SHALL decode funct3 as: 000 -> add, except sub only when op is 0110011 and funct7b5 is 1; 010 -> slt; 110 -> or; 111 -> and; any other funct3 in EXER or EXEI -> ILLEGAL next cycle with no reg_we.
REQ-031 SHALL, in BRANCH, drive srcA 10, srcB 00, sub and result_src 00, and set pc_we = taken, with taken per funct3: 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 !C; 111 C; 010/011 -> ILLEGAL; the FSM SHALL then go to FETCH.
REQ-032 SHALL, in JAL, drive srcA 01, srcB 10, add, result_src 00 and pc_we 1, then go to ALUWB.
REQ-033 SHALL drive imm_src combinationally from op_i in every state: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, otherwise 00.
REQ-034 SHALL make ILLEGAL absorbing: illegal_o is 1, all write enables are 0, and only reset exits.
REQ-035 SHALL, with MEM_WAIT_EN = 0, ignore mem_rdy_i and treat it as 1.
REQ-036 SHALL drive every unlisted select to 00/0 and alu_ctrl to 000.

Reset
REQ-037 SHALL, on rst_ni low, immediately set the state to FETCH and hold it there.
REQ-038 SHALL, while rst_ni is low, force pc_we, ir_we, mem_we, reg_we and illegal_o to 0 and hold the other outputs at their FETCH values.
REQ-039 SHALL, when reset is asserted mid-MEMWR, drop mem_we the same instant, asynchronously.

Structure
REQ-040 SHALL take opcode constants, the state enum and alu_ctrl codes from shared package rv32_pkg.
REQ-041 SHALL place funct/branch decode in sub-module rv32_alu_dec.

Verification
REQ-042 SHALL cover: R-add (op 0110011, f3 000, f7b5 0, rdy 1) -> FETCH, DECODE, EXER (alu_ctrl 000), ALUWB (reg_we 1), FETCH, 4 cycles.
REQ-043 SHALL cover: R f7b5 1 -> EXER alu_ctrl 001; I-type f3 000 f7b5 1 -> 000; f3 110 -> 011; f3 001 -> ILLEGAL.
REQ-044 SHALL cover: lw with mem_rdy_i low for 3 cycles in MEMRD -> MEMRD held 4 cycles, MEMWB reg_we 1, 8 cycles total.
REQ-045 SHALL cover: beq with flags 0100 -> pc_we 1 in BRANCH; flags 0000 -> pc_we 0; bltu with C 0 -> pc_we 1.
REQ-046 SHALL cover: op 1111111 -> ILLEGAL, illegal_o 1 held 10+ cycles; reset mid-MEMWR -> mem_we 0 asynchronously, then FETCH.
